mod_count_monitor: RTL and testbench
====================================

MOD_COUNT_MONITOR -- requirements
Module: mod_count_monitor

Interface
REQ-001 Parameter N, default 10: modulus of the observed counter; legal range 2..2^W.
REQ-002 Parameter W, default 4: count bit width.
REQ-003 Parameter LOCK_LEN, default 3: consecutive legal transitions required to declare lock; range 1..15.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port count_in  input  W  counter value under observation.
REQ-007 Port sample_en  input  1  count_in is valid this cycle and is to be evaluated.
REQ-008 Port dir_out  output  1  last inferred direction; 1 = up, 0 = down.
REQ-009 Port wrap_up  output  1  one-cycle pulse on an N-1 -> 0 step.
REQ-010 Port wrap_dn  output  1  one-cycle pulse on a 0 -> N-1 step.
REQ-011 Port err  output  1  one-cycle pulse on an illegal sample.
REQ-012 Port locked  output  1  monitor is in the LOCKED state.
REQ-013 Port err_cnt  output  8  saturating count of err pulses.

Function
REQ-014 The block SHALL hold the previous sample prev (W bits) and evaluate only cycles with sample_en=1; sample_en=0 cycles change no state and produce no pulses.
REQ-015 Expected values: up_exp = (prev==N-1) ? 0 : prev+1; dn_exp = (prev==0) ? N-1 : prev-1.
REQ-016 Classification priority: count_in>=N -> RANGE; count_in==prev -> HOLD; count_in==up_exp -> UP; count_in==dn_exp -> DOWN; otherwise -> JUMP. For N=2, UP takes precedence over DOWN.
REQ-017 UP SHALL set dir_out=1; DOWN SHALL set dir_out=0; HOLD SHALL leave dir_out unchanged.
REQ-018 wrap_up and wrap_dn SHALL pulse only for UP and DOWN wrap steps respectively, in any state except IDLE.
REQ-019 FSM states: IDLE, ACQ, LOCKED.
REQ-020 IDLE: an in-range sample SHALL be captured into prev and move the FSM to ACQ with good_cnt=0; a RANGE sample SHALL pulse err and remain in IDLE.
REQ-021 ACQ: UP, DOWN or HOLD SHALL increment good_cnt and update prev; when good_cnt reaches LOCK_LEN the FSM SHALL enter LOCKED. JUMP SHALL recapture prev, clear good_cnt and not pulse err. RANGE SHALL pulse err, clear good_cnt and keep prev.
REQ-022 LOCKED: UP, DOWN or HOLD SHALL update prev. JUMP SHALL pulse err, recapture prev and move to ACQ with good_cnt=0. RANGE SHALL pulse err, keep prev and move to ACQ.
REQ-023 All outputs SHALL be registered; every response appears on the cycle after the sample_en edge (latency 1).
REQ-024 err_cnt SHALL increment on each err pulse and saturate at 255.
REQ-025 Back-to-back sample_en on every cycle SHALL be supported with no throughput loss.

Reset
REQ-026 While reset=1: state=IDLE, prev=0, good_cnt=0, dir_out=1, wrap_up=0, wrap_dn=0, err=0, locked=0, err_cnt=0.
REQ-027 Reset asserted mid-operation SHALL abort immediately and asynchronously; the first sample after release SHALL be treated as an IDLE capture.

Structure
REQ-028 The FSM state encoding and the classification enumeration (RANGE, HOLD, UP, DOWN, JUMP) SHALL reside in a shared package, mod_counter_pkg.
REQ-029 The classification logic SHALL be a combinational sub-module, mod_step_classify, with ports prev, count_in and class; the parameters are N and W.

Verification
REQ-030 After reset, sample 0,1,2,3 on consecutive cycles -> locked=1 the cycle after the sample 3 edge, dir_out=1, err=0.
REQ-031 Locked, sample up 8,9,0 -> single wrap_up pulse after 0; then sample 9 -> dir_out=0 and a wrap_dn pulse.
REQ-032 Locked at 5, sample 7 -> err pulse, locked=0, err_cnt=1; then sample 8,9,0 -> relock.
REQ-033 Sample count_in=12 (N=10) in IDLE and in LOCKED -> err pulse each time; prev unchanged; err_cnt=2.
REQ-034 Locked at 4, sample_en low with random count_in for 5 cycles, then sample 4 -> HOLD, no err, dir_out unchanged.
REQ-035 Force 300 JUMP errors, then assert reset mid-stream -> err_cnt held at 255 before reset, all outputs at reset values during reset.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo-counter monitor: FSM states, step classes
// and the saturating error-counter helper.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCKED
    } mon_state_t;

    typedef enum logic [2:0] {
        CLS_RANGE,
        CLS_HOLD,
        CLS_UP,
        CLS_DOWN,
        CLS_JUMP
    } step_class_t;

    localparam int ERR_CNT_W  = 8;
    localparam int GOOD_CNT_W = 4;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mod_count_monitor_if.sv
// Observation bus of the counter monitor: sampled counter in, status out.
interface mod_count_monitor_if #(parameter int W = 4);

    logic [W-1:0] count_in;
    logic         sample_en;
    logic         dir_out;
    logic         wrap_up;
    logic         wrap_dn;
    logic         err;
    logic         locked;
    logic [7:0]   err_cnt;

    modport master (
        output count_in, sample_en,
        input  dir_out, wrap_up, wrap_dn, err, locked, err_cnt
    );

    modport slave (
        input  count_in, sample_en,
        output dir_out, wrap_up, wrap_dn, err, locked, err_cnt
    );

endinterface

// File: rtl/mod_step_classify.sv
// Combinational classifier of one counter step prev -> count_in modulo N.
module mod_step_classify
    import mod_counter_pkg::*;
#(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] count_in,
    output step_class_t  step_class
);

    // N may equal 2^W, so the range bound needs one extra bit.
    localparam logic [W:0]   N_EXT = N[W:0];
    localparam logic [W-1:0] N_MAX = W'(N - 1);

    logic [W-1:0] up_exp;
    logic [W-1:0] dn_exp;

    always_comb begin
        up_exp = (prev == N_MAX) ? '0 : prev + W'(1);
        dn_exp = (prev == '0) ? N_MAX : prev - W'(1);
        if ({1'b0, count_in} >= N_EXT)
            step_class = CLS_RANGE;
        else if (count_in == prev)
            step_class = CLS_HOLD;
        else if (count_in == up_exp)
            step_class = CLS_UP;
        else if (count_in == dn_exp)
            step_class = CLS_DOWN;
        else
            step_class = CLS_JUMP;
    end

endmodule

// File: rtl/mod_count_monitor.sv
// Watches a modulo-N counter, infers direction and wraps, locks after
// LOCK_LEN consecutive legal steps and counts illegal samples.
module mod_count_monitor
    import mod_counter_pkg::*;
#(
    parameter int N        = 10,
    parameter int W        = 4,
    parameter int LOCK_LEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    mod_count_monitor_if.slave  mon
);

    localparam logic [W-1:0]          N_MAX    = W'(N - 1);
    localparam logic [GOOD_CNT_W-1:0] LOCK_CNT = GOOD_CNT_W'(LOCK_LEN);

    mon_state_t              state;
    step_class_t             cls;
    logic [W-1:0]            prev;
    logic [GOOD_CNT_W-1:0]   good_cnt;
    logic                    dir_r;
    logic                    wrap_up_r;
    logic                    wrap_dn_r;
    logic                    err_r;
    logic [ERR_CNT_W-1:0]    err_cnt_r;
    logic                    err_evt;

    mod_step_classify #(.N(N), .W(W)) u_classify (
        .prev       (prev),
        .count_in   (mon.count_in),
        .step_class (cls)
    );

    // Out-of-range is always an error; a jump only once locked.
    assign err_evt = mon.sample_en &&
                     (cls == CLS_RANGE || (state == ST_LOCKED && cls == CLS_JUMP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            prev      <= '0;
            good_cnt  <= '0;
            dir_r     <= 1'b1;
            wrap_up_r <= 1'b0;
            wrap_dn_r <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            wrap_up_r <= 1'b0;
            wrap_dn_r <= 1'b0;
            err_r     <= err_evt;
            if (err_evt)
                err_cnt_r <= sat_inc(err_cnt_r);
            if (mon.sample_en) begin
                if (state != ST_IDLE) begin
                    if (cls == CLS_UP) begin
                        dir_r     <= 1'b1;
                        wrap_up_r <= (prev == N_MAX);
                    end
                    if (cls == CLS_DOWN) begin
                        dir_r     <= 1'b0;
                        wrap_dn_r <= (prev == '0);
                    end
                end
                case (state)
                    ST_IDLE: begin
                        if (cls != CLS_RANGE) begin
                            prev     <= mon.count_in;
                            good_cnt <= '0;
                            state    <= ST_ACQ;
                        end
                    end
                    ST_ACQ: begin
                        case (cls)
                            CLS_UP, CLS_DOWN, CLS_HOLD: begin
                                prev     <= mon.count_in;
                                good_cnt <= good_cnt + GOOD_CNT_W'(1);
                                if (good_cnt + GOOD_CNT_W'(1) == LOCK_CNT)
                                    state <= ST_LOCKED;
                            end
                            CLS_JUMP: begin
                                prev     <= mon.count_in;
                                good_cnt <= '0;
                            end
                            default: good_cnt <= '0;
                        endcase
                    end
                    ST_LOCKED: begin
                        case (cls)
                            CLS_UP, CLS_DOWN, CLS_HOLD: prev <= mon.count_in;
                            CLS_JUMP: begin
                                prev     <= mon.count_in;
                                good_cnt <= '0;
                                state    <= ST_ACQ;
                            end
                            default: begin
                                good_cnt <= '0;
                                state    <= ST_ACQ;
                            end
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mon.dir_out = dir_r;
    assign mon.wrap_up = wrap_up_r;
    assign mon.wrap_dn = wrap_dn_r;
    assign mon.err     = err_r;
    assign mon.locked  = (state == ST_LOCKED);
    assign mon.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_mod_count_monitor.sv
// Scoreboard bench for mod_count_monitor: directed scenarios plus random
// steps, checked against a modular-arithmetic reference model.
module tb_mod_count_monitor;

    localparam int N        = 10;
    localparam int W        = 4;
    localparam int LOCK_LEN = 3;
    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCK   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_count_monitor_if #(.W(W)) bus ();

    mod_count_monitor #(.N(N), .W(W), .LOCK_LEN(LOCK_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    typedef struct {
        int due;
        bit dir;
        bit wu;
        bit wd;
        bit er;
        bit lk;
        int ec;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    int m_mode, m_prev, m_good, m_errs;
    bit m_dir;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response expected for this cycle is popped and compared.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            me = q.pop_front();
            tests++;
            if (me.due != cyc || bus.dir_out !== me.dir || bus.wrap_up !== me.wu ||
                bus.wrap_dn !== me.wd || bus.err !== me.er || bus.locked !== me.lk ||
                bus.err_cnt !== 8'(me.ec)) begin
                fails++;
                $display("FAIL resp cyc=%0d due=%0d got dir=%b wu=%b wd=%b err=%b lk=%b ec=%0d want dir=%b wu=%b wd=%b err=%b lk=%b ec=%0d",
                         cyc, me.due, bus.dir_out, bus.wrap_up, bus.wrap_dn, bus.err, bus.locked,
                         bus.err_cnt, me.dir, me.wu, me.wd, me.er, me.lk, me.ec);
            end
        end
    end

    task automatic model_reset();
        m_mode = M_IDLE;
        m_prev = 0;
        m_good = 0;
        m_errs = 0;
        m_dir  = 1'b1;
    endtask

    task automatic step(input bit en, input int c);
        exp_t e;
        bit wu = 0;
        bit wd = 0;
        bit er = 0;
        int up;
        int dn;
        @(negedge clk);
        bus.sample_en = en;
        bus.count_in  = W'(c);
        if (en) begin
            up = (m_prev + 1) % N;
            dn = (m_prev + N - 1) % N;
            if (m_mode == M_IDLE) begin
                if (c >= N) er = 1;
                else begin
                    m_prev = c;
                    m_good = 0;
                    m_mode = M_ACQ;
                end
            end else if (c >= N) begin
                er     = 1;
                m_good = 0;
                m_mode = M_ACQ;
            end else if (c == m_prev || c == up || c == dn) begin
                if (c != m_prev && c == up) begin
                    m_dir = 1;
                    wu    = (m_prev == N - 1);
                end else if (c != m_prev) begin
                    m_dir = 0;
                    wd    = (m_prev == 0);
                end
                m_prev = c;
                if (m_mode == M_ACQ) begin
                    m_good++;
                    if (m_good == LOCK_LEN) m_mode = M_LOCK;
                end
            end else begin
                if (m_mode == M_LOCK) er = 1;
                m_prev = c;
                m_good = 0;
                m_mode = M_ACQ;
            end
            if (er && m_errs < 255) m_errs++;
        end
        e.due = cyc + 1;
        e.dir = m_dir;
        e.wu  = wu;
        e.wd  = wd;
        e.er  = er;
        e.lk  = (m_mode == M_LOCK);
        e.ec  = m_errs;
        q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if (bus.dir_out !== 1'b1 || bus.wrap_up !== 1'b0 || bus.wrap_dn !== 1'b0 ||
            bus.err !== 1'b0 || bus.locked !== 1'b0 || bus.err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL %s got dir=%b wu=%b wd=%b err=%b lk=%b ec=%0d want dir=1 wu=0 wd=0 err=0 lk=0 ec=0",
                     tag, bus.dir_out, bus.wrap_up, bus.wrap_dn, bus.err, bus.locked, bus.err_cnt);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain got %0d pending responses want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        bus.count_in  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset_init");
        reset = 1'b0;

        step(1, 12);
        for (int c = 0; c <= 3; c++) step(1, c);
        for (int c = 4; c <= 9; c++) step(1, c);
        step(1, 0);
        step(1, 9);
        for (int c = 8; c >= 5; c--) step(1, c);
        step(1, 7);
        step(1, 8);
        step(1, 9);
        step(1, 0);
        step(1, 12);
        for (int c = 1; c <= 4; c++) step(1, c);
        repeat (5) step(0, $urandom_range(0, 15));
        step(1, 4);

        for (int i = 0; i < 500; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 99);
            if (r < 35)      c = (m_prev + 1) % N;
            else if (r < 55) c = (m_prev + N - 1) % N;
            else if (r < 70) c = m_prev;
            else if (r < 85) c = $urandom_range(0, N - 1);
            else             c = $urandom_range(0, (1 << W) - 1);
            step($urandom_range(0, 99) < 80, c);
        end

        for (int i = 0; i < 300; i++) begin
            while (m_mode != M_LOCK) step(1, (m_prev + 1) % N);
            step(1, (m_prev + 5) % N);
        end
        drain();
        tests++;
        if (bus.err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL err_cnt_sat got %0d want 255", bus.err_cnt);
        end

        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.count_in  = 4'd3;
        #2 reset = 1'b1;
        #1 check_reset_vals("reset_async");
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("reset_hold");
        end
        bus.sample_en = 1'b0;
        reset = 1'b0;
        model_reset();

        for (int c = 5; c <= 9; c++) step(1, c);
        step(1, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
